// File: rtl/fft_out_serializer.sv
// Output stage of the 16-point FFT. It captures one frame of 16 complex bins and streams them one beat at a time.
// Optional macro FFT_REORDER_EN: when defined, bins leave in natural order; otherwise they leave in core (digit-reversed) order.
module fft_out_serializer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din_r0,
   input  logic [WIDTH-1:0] din_r1,
   input  logic [WIDTH-1:0] din_r2,
   input  logic [WIDTH-1:0] din_r3,
   input  logic [WIDTH-1:0] din_r4,
   input  logic [WIDTH-1:0] din_r5,
   input  logic [WIDTH-1:0] din_r6,
   input  logic [WIDTH-1:0] din_r7,
   input  logic [WIDTH-1:0] din_r8,
   input  logic [WIDTH-1:0] din_r9,
   input  logic [WIDTH-1:0] din_r10,
   input  logic [WIDTH-1:0] din_r11,
   input  logic [WIDTH-1:0] din_r12,
   input  logic [WIDTH-1:0] din_r13,
   input  logic [WIDTH-1:0] din_r14,
   input  logic [WIDTH-1:0] din_r15,
   input  logic [WIDTH-1:0] din_i0,
   input  logic [WIDTH-1:0] din_i1,
   input  logic [WIDTH-1:0] din_i2,
   input  logic [WIDTH-1:0] din_i3,
   input  logic [WIDTH-1:0] din_i4,
   input  logic [WIDTH-1:0] din_i5,
   input  logic [WIDTH-1:0] din_i6,
   input  logic [WIDTH-1:0] din_i7,
   input  logic [WIDTH-1:0] din_i8,
   input  logic [WIDTH-1:0] din_i9,
   input  logic [WIDTH-1:0] din_i10,
   input  logic [WIDTH-1:0] din_i11,
   input  logic [WIDTH-1:0] din_i12,
   input  logic [WIDTH-1:0] din_i13,
   input  logic [WIDTH-1:0] din_i14,
   input  logic [WIDTH-1:0] din_i15,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout_r,
   output logic [WIDTH-1:0] dout_i,
   output logic [3:0]       dout_idx,
   output logic             dout_last,
   output logic             busy
);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_cnt;
   logic [3:0]       w_cnt_nxt;
   logic             w_capture;
   logic             w_advance;
   logic             w_in_ready;
   logic [WIDTH-1:0] w_din_r [16];
   logic [WIDTH-1:0] w_din_i [16];
   logic [WIDTH-1:0] r_buf_r [16];
   logic [WIDTH-1:0] r_buf_i [16];
   logic [WIDTH-1:0] r_dout_r;
   logic [WIDTH-1:0] r_dout_i;

   // Buffer position that feeds natural bin k: p = 4*(k mod 4) + (k div 4).
   function automatic logic [3:0] f_pos(input logic [3:0] k);
`ifdef FFT_REORDER_EN
      return {k[1:0], k[3:2]};
`else
      return k;
`endif
   endfunction

   assign w_din_r[0]  = din_r0;   assign w_din_i[0]  = din_i0;
   assign w_din_r[1]  = din_r1;   assign w_din_i[1]  = din_i1;
   assign w_din_r[2]  = din_r2;   assign w_din_i[2]  = din_i2;
   assign w_din_r[3]  = din_r3;   assign w_din_i[3]  = din_i3;
   assign w_din_r[4]  = din_r4;   assign w_din_i[4]  = din_i4;
   assign w_din_r[5]  = din_r5;   assign w_din_i[5]  = din_i5;
   assign w_din_r[6]  = din_r6;   assign w_din_i[6]  = din_i6;
   assign w_din_r[7]  = din_r7;   assign w_din_i[7]  = din_i7;
   assign w_din_r[8]  = din_r8;   assign w_din_i[8]  = din_i8;
   assign w_din_r[9]  = din_r9;   assign w_din_i[9]  = din_i9;
   assign w_din_r[10] = din_r10;  assign w_din_i[10] = din_i10;
   assign w_din_r[11] = din_r11;  assign w_din_i[11] = din_i11;
   assign w_din_r[12] = din_r12;  assign w_din_i[12] = din_i12;
   assign w_din_r[13] = din_r13;  assign w_din_i[13] = din_i13;
   assign w_din_r[14] = din_r14;  assign w_din_i[14] = din_i14;
   assign w_din_r[15] = din_r15;  assign w_din_i[15] = din_i15;

   // Next-state, beat counter and handshake decode.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      w_advance   = 1'b0;
      w_in_ready  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = S_STREAM;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt   = 4'd0;
            end
         end
         S_STREAM: begin
            if (out_ready) begin
               if (r_cnt == 4'd15) begin
                  // The final beat frees the buffer, so a waiting frame slips in with no bubble.
                  w_in_ready = 1'b1;
                  w_cnt_nxt  = 4'd0;
                  if (in_valid) begin
                     w_capture = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_advance = 1'b1;
                  w_cnt_nxt = r_cnt + 4'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State and beat counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Frame buffer, which is loaded only on a capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < 16; j++) begin
            r_buf_r[j] <= '0;
            r_buf_i[j] <= '0;
         end
      end else if (w_capture) begin
         for (int j = 0; j < 16; j++) begin
            r_buf_r[j] <= w_din_r[j];
            r_buf_i[j] <= w_din_i[j];
         end
      end
   end

   // Registered data outputs. Bin 0 comes straight from the inputs on a capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout_r <= '0;
         r_dout_i <= '0;
      end else if (w_capture) begin
         r_dout_r <= w_din_r[f_pos(4'd0)];
         r_dout_i <= w_din_i[f_pos(4'd0)];
      end else if (w_advance) begin
         r_dout_r <= r_buf_r[f_pos(w_cnt_nxt)];
         r_dout_i <= r_buf_i[f_pos(w_cnt_nxt)];
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = (r_state == S_STREAM);
   assign busy      = (r_state == S_STREAM);
   assign dout_r    = r_dout_r;
   assign dout_i    = r_dout_i;
   assign dout_idx  = r_cnt;
   assign dout_last = (r_state == S_STREAM) && (r_cnt == 4'd15);

endmodule

// File: tb/tb_fft_out_serializer.sv
// Randomized and directed bench for fft_out_serializer. A beat-queue model is checked against the DUT on every falling edge.
module tb_fft_out_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] dout_r;
   logic [15:0] dout_i;
   logic [3:0]  dout_idx;
   logic        dout_last;
   logic        busy;
   logic [15:0] dr [16];
   logic [15:0] di [16];

   int n_cmp = 0;
   int n_err = 0;
   int n_cap = 0;

   typedef struct {
      logic [15:0] r;
      logic [15:0] i;
      logic [3:0]  idx;
   } beat_t;
   beat_t q[$];

   always #5 clk = ~clk;

   fft_out_serializer #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .din_r0(dr[0]), .din_r1(dr[1]), .din_r2(dr[2]), .din_r3(dr[3]),
      .din_r4(dr[4]), .din_r5(dr[5]), .din_r6(dr[6]), .din_r7(dr[7]),
      .din_r8(dr[8]), .din_r9(dr[9]), .din_r10(dr[10]), .din_r11(dr[11]),
      .din_r12(dr[12]), .din_r13(dr[13]), .din_r14(dr[14]), .din_r15(dr[15]),
      .din_i0(di[0]), .din_i1(di[1]), .din_i2(di[2]), .din_i3(di[3]),
      .din_i4(di[4]), .din_i5(di[5]), .din_i6(di[6]), .din_i7(di[7]),
      .din_i8(di[8]), .din_i9(di[9]), .din_i10(di[10]), .din_i11(di[11]),
      .din_i12(di[12]), .din_i13(di[13]), .din_i14(di[14]), .din_i15(di[15]),
      .out_valid(out_valid), .out_ready(out_ready), .dout_r(dout_r), .dout_i(dout_i),
      .dout_idx(dout_idx), .dout_last(dout_last), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pos_of(input int k);
`ifdef FFT_REORDER_EN
      return 4 * (k % 4) + k / 4;
`else
      return k;
`endif
   endfunction

   // Model: the queue holds the beats still owed for the held frame.
   always @(posedge clk or posedge rst) begin
      logic rdy;
      beat_t b;
      if (rst) begin
         q.delete();
      end else begin
         rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (in_valid && rdy) begin
            n_cap++;
            for (int k = 0; k < 16; k++) begin
               b.r = dr[pos_of(k)];
               b.i = di[pos_of(k)];
               b.idx = 4'(k);
               q.push_back(b);
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
         chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
         chk("in_ready", {31'd0, in_ready},
             {31'd0, (q.size() == 0) || (q.size() == 1 && out_ready)});
         if (q.size() != 0) begin
            chk("dout_r", {16'd0, dout_r}, {16'd0, q[0].r});
            chk("dout_i", {16'd0, dout_i}, {16'd0, q[0].i});
            chk("dout_idx", {28'd0, dout_idx}, {28'd0, q[0].idx});
            chk("dout_last", {31'd0, dout_last}, {31'd0, q[0].idx == 4'd15});
         end
      end
   end

   task automatic rand_frame();
      for (int p = 0; p < 16; p++) begin
         dr[p] = 16'($urandom);
         di[p] = 16'($urandom);
      end
   endtask

   task automatic wait_idx(input logic [3:0] want);
      int t;
      t = 0;
      @(negedge clk);
      while (!(out_valid && dout_idx == want) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("wait_idx_timeout", {31'd0, t >= 100}, 32'd0);
   endtask

   initial begin
      int lit [16];
      logic [15:0] hr, hi;
      logic [3:0]  hidx;
      int vcnt;
      int caps;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      for (int p = 0; p < 16; p++) begin dr[p] = 16'd0; di[p] = 16'd0; end
      #2;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_dout_r", {16'd0, dout_r}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      // Idle for 20 cycles with no frame offered.
      repeat (20) begin
         @(negedge clk);
         chk("idle_valid", {31'd0, out_valid}, 32'd0);
      end

      // Single frame with din_r[p] = p and din_i[p] = -p, compared against literal expectations.
`ifdef FFT_REORDER_EN
      lit = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
`else
      lit = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
      @(posedge clk); #1;
      for (int p = 0; p < 16; p++) begin dr[p] = 16'(p); di[p] = 16'(0 - p); end
      in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      for (int b = 0; b < 16; b++) begin
         @(negedge clk);
         chk("lit_dout_r", {16'd0, dout_r}, 32'(lit[b]));
         chk("lit_dout_i", {16'd0, dout_i}, {16'd0, 16'(0 - lit[b])});
         chk("lit_last", {31'd0, dout_last}, {31'd0, b == 15});
      end
      @(negedge clk);
      chk("lit_end_valid", {31'd0, out_valid}, 32'd0);

      // Backpressure: hold out_ready low for 3 cycles at beat 5.
      @(posedge clk); #1 rand_frame(); in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      wait_idx(4'd5);
      hr = dout_r; hi = dout_i; hidx = dout_idx;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_r", {16'd0, dout_r}, {16'd0, hr});
         chk("bp_i", {16'd0, dout_i}, {16'd0, hi});
         chk("bp_idx", {28'd0, dout_idx}, 32'd5);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      repeat (15) @(negedge clk);

      // Back-to-back frames: B waits on in_valid and is captured on A's last beat.
      @(posedge clk); #1;
      for (int p = 0; p < 16; p++) begin dr[p] = 16'h1111; di[p] = 16'h1111; end
      in_valid = 1'b1;
      @(posedge clk); #1;
      for (int p = 0; p < 16; p++) begin dr[p] = 16'h2222; di[p] = 16'h2222; end
      vcnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid) vcnt++;
         if (c == 0) chk("b2b_A", {16'd0, dout_r}, 32'h1111);
         if (c == 16) begin
            chk("b2b_B", {16'd0, dout_r}, 32'h2222);
            in_valid = 1'b0;
         end
      end
      chk("b2b_valid_cycles", 32'(vcnt), 32'd32);

      // Reset at beat 7, then a fresh frame.
      @(posedge clk); #1 rand_frame(); in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      wait_idx(4'd7);
      #2 rst = 1'b1;
      #1;
      chk("mrst_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_r", {16'd0, dout_r}, 32'd0);
      chk("mrst_i", {16'd0, dout_i}, 32'd0);
      chk("mrst_idx", {28'd0, dout_idx}, 32'd0);
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      rand_frame(); in_valid = 1'b1;
      hr = dr[0];
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("fresh_idx", {28'd0, dout_idx}, 32'd0);
      chk("fresh_r", {16'd0, dout_r}, {16'd0, hr});
      repeat (20) @(negedge clk);

      // Random traffic. A frame is held until the model reports it was captured.
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         if (in_valid && n_cap != caps) in_valid = 1'b0;
         if (!in_valid) begin
            rand_frame();
            in_valid = ($urandom_range(0, 99) < 40);
            caps = n_cap;
         end
         out_ready = ($urandom_range(0, 99) < 70);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (40) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
